alu_core: RTL and testbench

//  Clocked, parametrised 65C02 ALU; successor to the latch-only ALU transfer block.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_core_bcd_adjust.sv | 51 +++++
 rtl/alu_core.sv | 187 ++++++++++++++++++
 tb/tb_alu_core.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the clocked 65C02-style ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADC   = 4'd0,
    SBC   = 4'd1,
    AND   = 4'd2,
    ORA   = 4'd3,
    EOR   = 4'd4,
    ASL   = 4'd5,
    LSR   = 4'd6,
    ROL   = 4'd7,
    ROR   = 4'd8,
    INC   = 4'd9,
    DEC   = 4'd10,
    CMP   = 4'd11,
    BIT   = 4'd12,
    IXADD = 4'd13,
    PASS  = 4'd14
  } alu_op_t;

  // Bit positions inside the {N,V,Z,C} flag vectors
  localparam int FLG_N = 3;
  localparam int FLG_V = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_C = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ADJ  = 2'd2
  } state_t;

  // Which of {N,V,Z,C} an op writes; undefined codes behave as PASS.
  function automatic logic [3:0] flag_mask(input logic [3:0] op);
    case (op)
      ADC, SBC:                flag_mask = 4'b1111;
      ASL, LSR, ROL, ROR, CMP: flag_mask = 4'b1011;
      BIT:                     flag_mask = 4'b1110;
      IXADD:                   flag_mask = 4'b0001;
      default:                 flag_mask = 4'b1010;
    endcase
  endfunction

endpackage

// File: rtl/alu_core_bcd_adjust.sv
// Combinational BCD add/subtract with per-nibble +6/-6 correction.
module alu_bcd_adjust #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             subtract,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int NIB = WIDTH / 4;

  logic       c_s;
  logic [4:0] t_s;
  logic [3:0] bn_s;

  // Ripple through the nibbles, correcting each digit and passing the decimal carry up
  always_comb begin
    c_s    = carry_in;
    t_s    = 5'd0;
    bn_s   = 4'd0;
    result = {WIDTH{1'b0}};
    for (int i = 0; i < NIB; i++) begin
      bn_s = subtract ? ~b[i*4 +: 4] : b[i*4 +: 4];
      t_s  = {1'b0, a[i*4 +: 4]} + {1'b0, bn_s} + {4'd0, c_s};
      if (subtract) begin
        // Carry out of the nibble means no borrow; a borrow needs -6
        if (t_s[4]) begin
          result[i*4 +: 4] = t_s[3:0];
          c_s              = 1'b1;
        end else begin
          result[i*4 +: 4] = t_s[3:0] - 4'd6;
          c_s              = 1'b0;
        end
      end else begin
        // Digit above 9 (including binary carry) is pushed past 15 by +6
        if (t_s > 5'd9) begin
          result[i*4 +: 4] = t_s[3:0] + 4'd6;
          c_s              = 1'b1;
        end else begin
          result[i*4 +: 4] = t_s[3:0];
          c_s              = 1'b0;
        end
      end
    end
    carry_out = c_s;
  end

endmodule

// File: rtl/alu_core.sv
// Clocked 65C02 ALU: operand registers, start/busy/done FSM, registered result and flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DECIMAL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_load,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             db_load,
  input  logic [WIDTH-1:0] db_in,
  input  logic             addr_load,
  input  logic [WIDTH-1:0] addr_in,
  input  logic             start,
  input  logic [3:0]       op_in,
  input  logic             carry_in,
  input  logic             decimal_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_out,
  output logic [3:0]       flags_we,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] addr_out
);

  localparam int MSB = WIDTH - 1;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r, c_r;
  logic [WIDTH-1:0] opa_r, opb_r, opc_r;
  logic [3:0]       op_r;
  logic             cin_r, dec_r;

  logic [WIDTH-1:0] bop_s, bin_res_s, nz_src_s, bcd_res_s;
  logic [WIDTH:0]   sum_s, cmp_s, ix_s;
  logic             flag_n_s, flag_v_s, flag_z_s, flag_c_s, bcd_c_s;
  logic             decimal_op_s, sub_s;
  logic [3:0]       flags_bin_s, flags_dec_s;

  assign acc_out  = a_r;
  assign db_out   = b_r;
  assign addr_out = c_r;

  // Operand registers load in IDLE; start snapshots the pre-load values for the op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      c_r   <= {WIDTH{1'b0}};
      opa_r <= {WIDTH{1'b0}};
      opb_r <= {WIDTH{1'b0}};
      opc_r <= {WIDTH{1'b0}};
      op_r  <= 4'd0;
      cin_r <= 1'b0;
      dec_r <= 1'b0;
    end else if (state_r == IDLE) begin
      if (acc_load)  a_r <= acc_in;
      if (db_load)   b_r <= db_in;
      if (addr_load) c_r <= addr_in;
      if (start) begin
        opa_r <= a_r;
        opb_r <= b_r;
        opc_r <= c_r;
        op_r  <= op_in;
        cin_r <= carry_in;
        dec_r <= decimal_in;
      end
    end
  end

  // WIDTH+1-bit adders for ADC/SBC, compare and index add
  always_comb begin
    sub_s = (op_r == SBC);
    bop_s = sub_s ? ~opb_r : opb_r;
    sum_s = {1'b0, opa_r} + {1'b0, bop_s} + {{WIDTH{1'b0}}, cin_r};
    cmp_s = {1'b0, opa_r} + {1'b0, ~opb_r} + {{WIDTH{1'b0}}, 1'b1};
    ix_s  = {1'b0, opc_r} + {1'b0, opb_r};
  end

  // Binary result and flag selection; flags an op does not touch read as 0
  always_comb begin
    bin_res_s = opb_r;
    flag_v_s  = 1'b0;
    flag_c_s  = 1'b0;
    case (op_r)
      ADC, SBC: begin
        bin_res_s = sum_s[MSB:0];
        flag_c_s  = sum_s[WIDTH];
        flag_v_s  = (opa_r[MSB] == bop_s[MSB]) && (sum_s[MSB] != opa_r[MSB]);
      end
      AND:   bin_res_s = opa_r & opb_r;
      ORA:   bin_res_s = opa_r | opb_r;
      EOR:   bin_res_s = opa_r ^ opb_r;
      ASL:   begin bin_res_s = {opa_r[MSB-1:0], 1'b0}; flag_c_s = opa_r[MSB]; end
      LSR:   begin bin_res_s = {1'b0, opa_r[MSB:1]};   flag_c_s = opa_r[0];   end
      ROL:   begin bin_res_s = {opa_r[MSB-1:0], cin_r}; flag_c_s = opa_r[MSB]; end
      ROR:   begin bin_res_s = {cin_r, opa_r[MSB:1]};   flag_c_s = opa_r[0];   end
      INC:   bin_res_s = opa_r + {{(WIDTH-1){1'b0}}, 1'b1};
      DEC:   bin_res_s = opa_r - {{(WIDTH-1){1'b0}}, 1'b1};
      CMP:   begin bin_res_s = opa_r; flag_c_s = cmp_s[WIDTH]; end
      BIT:   begin bin_res_s = opa_r; flag_v_s = opb_r[MSB-1]; end
      IXADD: begin bin_res_s = ix_s[MSB:0]; flag_c_s = ix_s[WIDTH]; end
      default: bin_res_s = opb_r;
    endcase
    nz_src_s = (op_r == CMP) ? cmp_s[MSB:0] : bin_res_s;
    if (op_r == BIT) begin
      flag_n_s = opb_r[MSB];
      flag_z_s = ((opa_r & opb_r) == {WIDTH{1'b0}});
    end else begin
      flag_n_s = nz_src_s[MSB];
      flag_z_s = (nz_src_s == {WIDTH{1'b0}});
    end
    flags_bin_s = {flag_n_s, flag_v_s, flag_z_s, flag_c_s} & flag_mask(op_r);
    // Decimal flags: N/Z from the adjusted value, V kept from the binary stage
    flags_dec_s = {bcd_res_s[MSB], flag_v_s, (bcd_res_s == {WIDTH{1'b0}}), bcd_c_s};
    decimal_op_s = (DECIMAL_EN != 0) && dec_r && ((op_r == ADC) || (op_r == SBC));
  end

  generate
    if (DECIMAL_EN != 0) begin : g_bcd
      alu_bcd_adjust #(.WIDTH(WIDTH)) u_bcd (
        .a        (opa_r),
        .b        (opb_r),
        .carry_in (cin_r),
        .subtract (sub_s),
        .result   (bcd_res_s),
        .carry_out(bcd_c_s)
      );
    end else begin : g_no_bcd
      assign bcd_res_s = {WIDTH{1'b0}};
      assign bcd_c_s   = 1'b0;
    end
  endgenerate

  // FSM next state: decimal ADC/SBC detour through ADJ
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = EXEC;
        else       state_s = IDLE;
      end
      EXEC: begin
        if (decimal_op_s) state_s = ADJ;
        else              state_s = IDLE;
      end
      ADJ:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Registered outputs: result/flags update only with the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= {WIDTH{1'b0}};
      flags_out <= 4'd0;
      flags_we  <= 4'd0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_s != IDLE);
      if ((state_r == EXEC) && !decimal_op_s) begin
        result    <= bin_res_s;
        flags_out <= flags_bin_s;
        flags_we  <= flag_mask(op_r);
        done      <= 1'b1;
      end else if (state_r == ADJ) begin
        result    <= bcd_res_s;
        flags_out <= flags_dec_s;
        flags_we  <= 4'b1111;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: 8-bit decimal build plus a 16-bit binary-only build.
module tb_alu_core;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-bit, DECIMAL_EN=1 instance
  logic acc_load_8 = 0, db_load_8 = 0, addr_load_8 = 0, start_8 = 0, carry_in_8 = 0, decimal_in_8 = 0;
  logic [7:0] acc_in_8 = 0, db_in_8 = 0, addr_in_8 = 0;
  logic [3:0] op_in_8 = 0;
  logic busy_8, done_8;
  logic [7:0] result_8, acc_out_8, db_out_8, addr_out_8;
  logic [3:0] flags_out_8, flags_we_8;

  // 16-bit, DECIMAL_EN=0 instance
  logic acc_load_16 = 0, db_load_16 = 0, addr_load_16 = 0, start_16 = 0, carry_in_16 = 0, decimal_in_16 = 0;
  logic [15:0] acc_in_16 = 0, db_in_16 = 0, addr_in_16 = 0;
  logic [3:0] op_in_16 = 0;
  logic busy_16, done_16;
  logic [15:0] result_16, acc_out_16, db_out_16, addr_out_16;
  logic [3:0] flags_out_16, flags_we_16;

  alu_core #(.WIDTH(8), .DECIMAL_EN(1)) dut8 (
    .clk(clk), .reset(reset),
    .acc_load(acc_load_8), .acc_in(acc_in_8), .db_load(db_load_8), .db_in(db_in_8),
    .addr_load(addr_load_8), .addr_in(addr_in_8), .start(start_8), .op_in(op_in_8),
    .carry_in(carry_in_8), .decimal_in(decimal_in_8), .busy(busy_8), .done(done_8),
    .result(result_8), .flags_out(flags_out_8), .flags_we(flags_we_8),
    .acc_out(acc_out_8), .db_out(db_out_8), .addr_out(addr_out_8));

  alu_core #(.WIDTH(16), .DECIMAL_EN(0)) dut16 (
    .clk(clk), .reset(reset),
    .acc_load(acc_load_16), .acc_in(acc_in_16), .db_load(db_load_16), .db_in(db_in_16),
    .addr_load(addr_load_16), .addr_in(addr_in_16), .start(start_16), .op_in(op_in_16),
    .carry_in(carry_in_16), .decimal_in(decimal_in_16), .busy(busy_16), .done(done_16),
    .result(result_16), .flags_out(flags_out_16), .flags_we(flags_we_16),
    .acc_out(acc_out_16), .db_out(db_out_16), .addr_out(addr_out_16));

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    logic [3:0]  we;
    int          due;
    string       tag;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for 8-bit binary ops: returns {we, flags, result}
  function automatic logic [15:0] model8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic cin);
    int t, sa, sb, ci;
    logic [7:0] r;
    logic n, v, z, cf, nz_auto;
    logic [3:0] we;
    sa = $signed(a); sb = $signed(b); ci = cin;
    r = b; v = 0; cf = 0; n = 0; z = 0; nz_auto = 1; we = 4'b1010; t = 0;
    case (op)
      4'd0:  begin t = a + b + ci; r = t[7:0]; cf = (t > 255);
                   t = sa + sb + ci; v = (t < -128) || (t > 127); we = 4'b1111; end
      4'd1:  begin t = a - b - (1 - ci); r = t[7:0]; cf = (t >= 0);
                   t = sa - sb - (1 - ci); v = (t < -128) || (t > 127); we = 4'b1111; end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  begin r = a << 1; cf = a[7]; we = 4'b1011; end
      4'd6:  begin r = a >> 1; cf = a[0]; we = 4'b1011; end
      4'd7:  begin r = {a[6:0], cin}; cf = a[7]; we = 4'b1011; end
      4'd8:  begin r = {cin, a[7:1]}; cf = a[0]; we = 4'b1011; end
      4'd9:  r = a + 8'd1;
      4'd10: r = a - 8'd1;
      4'd11: begin r = a; t = a - b; n = t[7]; z = (a == b); cf = (a >= b); nz_auto = 0; we = 4'b1011; end
      4'd12: begin r = a; n = b[7]; v = b[6]; z = ((a & b) == 8'd0); nz_auto = 0; we = 4'b1110; end
      4'd13: begin t = c + b; r = t[7:0]; cf = (t > 255); we = 4'b0001; end
      default: r = b;
    endcase
    if (nz_auto) begin n = r[7]; z = (r == 8'd0); end
    return {we, {n, v, z, cf} & we, r};
  endfunction

  // Decimal model for valid BCD operands: integer arithmetic on two-digit numbers
  function automatic logic [15:0] dec8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int da, db, s;
    logic cf, v;
    logic [7:0] r;
    logic [15:0] bin;
    da = a[7:4] * 10 + a[3:0];
    db = b[7:4] * 10 + b[3:0];
    if (op == 4'd0) begin s = da + db + cin; cf = (s > 99); if (cf) s = s - 100; end
    else begin s = da - db - (1 - cin); cf = (s >= 0); if (!cf) s = s + 100; end
    r = 8'(((s / 10) << 4) + (s % 10));
    bin = model8(op, a, b, 8'd0, cin);
    v = bin[10];
    return {4'b1111, r[7], v, (r == 8'd0), cf, r};
  endfunction

  // Scoreboard: every done pops one expectation and compares result, flags, mask and timing
  always @(negedge clk) begin
    if (done_8) begin
      if (q8.size() == 0) check("dut8 spurious done", 1, 0);
      else begin
        e8 = q8.pop_front();
        check({e8.tag, " result"}, result_8, e8.res);
        check({e8.tag, " flags"}, flags_out_8, e8.flg);
        check({e8.tag, " we"}, flags_we_8, e8.we);
        check({e8.tag, " latency"}, cyc, e8.due);
      end
    end
    if (done_16) begin
      if (q16.size() == 0) check("dut16 spurious done", 1, 0);
      else begin
        e16 = q16.pop_front();
        check({e16.tag, " result"}, result_16, e16.res);
        check({e16.tag, " flags"}, flags_out_16, e16.flg);
        check({e16.tag, " we"}, flags_we_16, e16.we);
        check({e16.tag, " latency"}, cyc, e16.due);
      end
    end
  end

  task automatic drain(input string tag);
    for (int k = 0; k < 8; k++) begin
      if (q8.size() == 0 && q16.size() == 0) break;
      @(negedge clk);
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      check({tag, " timeout"}, q8.size() + q16.size(), 0);
      q8.delete();
      q16.delete();
    end
  endtask

  task automatic push8(input string tag, input logic [7:0] r, input logic [3:0] f, input logic [3:0] w, input int lat);
    exp_t e;
    e.res = {8'h00, r}; e.flg = f; e.we = w; e.due = cyc + 1 + lat; e.tag = tag;
    q8.push_back(e);
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    acc_in_8 = a; db_in_8 = b; addr_in_8 = c;
    acc_load_8 = 1; db_load_8 = 1; addr_load_8 = 1;
    @(negedge clk);
    acc_load_8 = 0; db_load_8 = 0; addr_load_8 = 0;
  endtask

  task automatic issue8(input string tag, input logic [3:0] op, input logic cin, input logic dec,
                        input logic [7:0] r, input logic [3:0] f, input logic [3:0] w, input int lat);
    op_in_8 = op; carry_in_8 = cin; decimal_in_8 = dec; start_8 = 1;
    push8(tag, r, f, w, lat);
    @(negedge clk);
    start_8 = 0;
    drain(tag);
  endtask

  task automatic issue16(input string tag, input logic [3:0] op, input logic cin, input logic dec,
                         input logic [15:0] r, input logic [3:0] f, input logic [3:0] w);
    exp_t e;
    op_in_16 = op; carry_in_16 = cin; decimal_in_16 = dec; start_16 = 1;
    e.res = r; e.flg = f; e.we = w; e.due = cyc + 2; e.tag = tag;
    q16.push_back(e);
    @(negedge clk);
    start_16 = 0;
    drain(tag);
  endtask

  task automatic check_zero8(input string tag);
    check({tag, " busy"}, busy_8, 0);
    check({tag, " done"}, done_8, 0);
    check({tag, " result"}, result_8, 0);
    check({tag, " flags"}, flags_out_8, 0);
    check({tag, " we"}, flags_we_8, 0);
    check({tag, " acc"}, acc_out_8, 0);
    check({tag, " db"}, db_out_8, 0);
    check({tag, " addr"}, addr_out_8, 0);
  endtask

  logic [3:0]  r_op;
  logic [7:0]  r_a, r_b, r_c;
  logic        r_cin, r_dec;
  logic [15:0] mdl;
  int          r_lat;

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_zero8("reset");
    check("reset busy16", busy_16, 0);
    check("reset result16", result_16, 0);
    reset = 1'b0;
    @(negedge clk);

    // Simultaneous loads all capture
    load8(8'h11, 8'h22, 8'h33);
    check("sim load acc", acc_out_8, 8'h11);
    check("sim load db", db_out_8, 8'h22);
    check("sim load addr", addr_out_8, 8'h33);

    load8(8'h50, 8'h50, 8'h00);
    issue8("adc bin", ADC, 1'b0, 1'b0, 8'hA0, 4'b1100, 4'b1111, 1);

    load8(8'h58, 8'h46, 8'h00);
    issue8("adc dec", ADC, 1'b1, 1'b1, 8'h05, 4'b0101, 4'b1111, 2);

    load8(8'h12, 8'h21, 8'h00);
    issue8("sbc dec", SBC, 1'b1, 1'b1, 8'h91, 4'b1000, 4'b1111, 2);

    load8(8'h40, 8'h40, 8'h00);
    issue8("cmp eq", CMP, 1'b0, 1'b1, 8'h40, 4'b0011, 4'b1011, 1);

    // Load together with start: the op sees the old A
    acc_in_8 = 8'h99; acc_load_8 = 1;
    op_in_8 = INC; carry_in_8 = 0; decimal_in_8 = 0; start_8 = 1;
    push8("load+start inc", 8'h41, 4'b0000, 4'b1010, 1);
    @(negedge clk);
    acc_load_8 = 0; start_8 = 0;
    drain("load+start");
    check("load+start acc", acc_out_8, 8'h99);

    // Loads and start while busy are ignored
    load8(8'h10, 8'h20, 8'h30);
    op_in_8 = PASS; carry_in_8 = 0; decimal_in_8 = 0; start_8 = 1;
    push8("pass busy", 8'h20, 4'b0000, 4'b1010, 1);
    @(negedge clk);
    start_8 = 0;
    check("busy in exec", busy_8, 1);
    acc_in_8 = 8'hEE; db_in_8 = 8'hEE; addr_in_8 = 8'hEE;
    acc_load_8 = 1; db_load_8 = 1; addr_load_8 = 1; op_in_8 = INC; start_8 = 1;
    @(negedge clk);
    acc_load_8 = 0; db_load_8 = 0; addr_load_8 = 0; start_8 = 0;
    drain("busy ignore");
    repeat (3) @(negedge clk);
    check("busy ignore acc", acc_out_8, 8'h10);
    check("busy ignore db", db_out_8, 8'h20);
    check("busy ignore addr", addr_out_8, 8'h30);

    // 16-bit binary-only build
    acc_in_16 = 16'h0001; acc_load_16 = 1;
    @(negedge clk);
    acc_load_16 = 0;
    issue16("ror16", ROR, 1'b1, 1'b1, 16'h8000, 4'b1001, 4'b1011);
    acc_in_16 = 16'h1234; db_in_16 = 16'h0101; acc_load_16 = 1; db_load_16 = 1;
    @(negedge clk);
    acc_load_16 = 0; db_load_16 = 0;
    issue16("adc16 dec ignored", ADC, 1'b0, 1'b1, 16'h1335, 4'b0000, 4'b1111);

    // Reset in the middle of EXEC: no done, outputs cleared at once
    load8(8'h58, 8'h46, 8'h00);
    op_in_8 = ADC; carry_in_8 = 1; decimal_in_8 = 1; start_8 = 1;
    @(posedge clk);
    #1;
    check("pre-reset busy", busy_8, 1);
    reset = 1'b1; start_8 = 0;
    #1;
    check_zero8("mid reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Randomised ops against the reference models
    for (int i = 0; i < 30; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = 8'($urandom);
      r_b   = 8'($urandom);
      r_c   = 8'($urandom);
      r_cin = 1'($urandom_range(0, 1));
      r_dec = 1'($urandom_range(0, 1));
      if (r_dec && (r_op == 4'd0 || r_op == 4'd1)) begin
        r_a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        r_b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        mdl = dec8(r_op, r_a, r_b, r_cin);
        r_lat = 2;
      end else begin
        mdl = model8(r_op, r_a, r_b, r_c, r_cin);
        r_lat = 1;
      end
      load8(r_a, r_b, r_c);
      issue8($sformatf("rand op%0d a%0h b%0h", r_op, r_a, r_b), r_op, r_cin, r_dec,
             mdl[7:0], mdl[11:8], mdl[15:12], r_lat);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
